// File: rtl/vga_timing_gen.sv
// Raster timing source: hcount/vcount counters, phase FSMs, hsync/vsync and line/frame strobes.
// Latency: counters, active and strobes registered (1 clk); hsync/vsync add SYNC_DLY further clk.
// Backpressure: none; pix_en qualifies counter advance, the sync delay chain runs every clk.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int SYNC_DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FP_BEG = 10'(H_ACTIVE);
  localparam logic [9:0] H_SY_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_BEG = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_FP_BEG = 10'(V_ACTIVE);
  localparam logic [9:0] V_SY_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_BEG = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  phase_t     h_ph, h_ph_nxt;
  phase_t     v_ph, v_ph_nxt;
  logic [9:0] h_nxt, v_nxt;
  logic       h_wrap;
  logic       v_advance;

  // The delay chain: stage 0 is the registered undelayed sync, the last stage drives the pin.
  logic [SYNC_DLY:0] hs_pipe;
  logic [SYNC_DLY:0] vs_pipe;

  // Next counter values: advance on pix_en, wrap the line at H_TOTAL-1 and the frame at V_TOTAL-1.
  always_comb begin
    h_nxt     = hcount;
    v_nxt     = vcount;
    h_wrap    = (hcount == H_LAST);
    v_advance = pix_en && h_wrap;
    if (pix_en) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end else begin
        h_nxt = hcount + 10'd1;
      end
    end
  end

  // Phase transitions follow the count that will be presented next clk.
  always_comb begin
    h_ph_nxt = h_ph;
    v_ph_nxt = v_ph;
    if (pix_en) begin
      case (h_ph)
        PH_ACTIVE: if (h_nxt == H_FP_BEG) h_ph_nxt = PH_FRONT;
        PH_FRONT:  if (h_nxt == H_SY_BEG) h_ph_nxt = PH_SYNC;
        PH_SYNC:   if (h_nxt == H_BP_BEG) h_ph_nxt = PH_BACK;
        default:   if (h_nxt == 10'd0)    h_ph_nxt = PH_ACTIVE;
      endcase
    end
    if (v_advance) begin
      case (v_ph)
        PH_ACTIVE: if (v_nxt == V_FP_BEG) v_ph_nxt = PH_FRONT;
        PH_FRONT:  if (v_nxt == V_SY_BEG) v_ph_nxt = PH_SYNC;
        PH_SYNC:   if (v_nxt == V_BP_BEG) v_ph_nxt = PH_BACK;
        default:   if (v_nxt == 10'd0)    v_ph_nxt = PH_ACTIVE;
      endcase
    end
  end

  // Phase state registers for both axes.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_ph <= PH_ACTIVE;
      v_ph <= PH_ACTIVE;
    end else begin
      h_ph <= h_ph_nxt;
      v_ph <= v_ph_nxt;
    end
  end

  // Counters, active flag and single-clk strobes; strobes self-clear whenever pix_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      active      <= 1'b1;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      active      <= (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);
      line_end    <= pix_en && (h_nxt == H_LAST);
      frame_start <= v_advance && (vcount == V_LAST);
    end
  end

  // Sync pipeline runs every clk; reset flushes every stage to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_pipe <= {(SYNC_DLY + 1){~H_POL}};
      vs_pipe <= {(SYNC_DLY + 1){~V_POL}};
    end else begin
      hs_pipe[0] <= (h_ph_nxt == PH_SYNC) ? H_POL : ~H_POL;
      vs_pipe[0] <= (v_ph_nxt == PH_SYNC) ? V_POL : ~V_POL;
      for (int i = 1; i <= SYNC_DLY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign hsync = hs_pipe[SYNC_DLY];
  assign vsync = vs_pipe[SYNC_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing at SYNC_DLY 0 and 1, plus a tiny raster with
// inverted hsync polarity and SYNC_DLY 2 so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] a_hc, a_vc, b_hc, b_vc, c_hc, c_vc;
  logic a_act, a_hs, a_vs, a_le, a_fs;
  logic b_act, b_hs, b_vs, b_le, b_fs;
  logic c_act, c_hs, c_vs, c_le, c_fs;

  vga_timing_gen #(.SYNC_DLY(0)) u_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(a_hc), .vcount(a_vc), .active(a_act),
    .hsync(a_hs), .vsync(a_vs), .line_end(a_le), .frame_start(a_fs));

  vga_timing_gen u_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(b_hc), .vcount(b_vc), .active(b_act),
    .hsync(b_hs), .vsync(b_vs), .line_end(b_le), .frame_start(b_fs));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                   .H_POL(1'b1), .V_POL(1'b0), .SYNC_DLY(2)) u_c (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(c_hc), .vcount(c_vc), .active(c_act),
    .hsync(c_hs), .vsync(c_vs), .line_end(c_le), .frame_start(c_fs));

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int dly;
  } cfg_t;

  // Reference state: number of pixel ticks since reset, plus sync history (bit k = k clk ago).
  typedef struct {
    int       t;
    bit [3:0] rh;
    bit [3:0] rv;
    bit       le;
    bit       fs;
  } mdl_t;

  typedef struct {
    bit r, en;
    int hc, vc, act, hs, le, fs;
  } vec_t;

  cfg_t ca, cb, cc;
  mdl_t ma, mb, mc;
  int n_chk = 0;
  int n_fail = 0;

  function automatic mdl_t mstep(mdl_t m, cfg_t c, bit r, bit en);
    int ht = c.ha + c.hf + c.hs + c.hb;
    int vt = c.va + c.vf + c.vs + c.vb;
    int h, v;
    bit sh, sv;
    if (r) begin
      m.t  = 0;
      m.le = 1'b0;
      m.fs = 1'b0;
      m.rh = {4{~c.hp}};
      m.rv = {4{~c.vp}};
      return m;
    end
    if (en) begin
      m.t  = (m.t + 1) % (ht * vt);
      m.le = ((m.t % ht) == ht - 1);
      m.fs = (m.t == 0);
    end else begin
      m.le = 1'b0;
      m.fs = 1'b0;
    end
    h  = m.t % ht;
    v  = m.t / ht;
    sh = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
    sv = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
    m.rh = {m.rh[2:0], sh};
    m.rv = {m.rv[2:0], sv};
    return m;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_inst(string tag, cfg_t c, mdl_t m, int hc, int vc, int act,
                          int hs, int vs, int le, int fs);
    int ht = c.ha + c.hf + c.hs + c.hb;
    int h = m.t % ht;
    int v = m.t / ht;
    chk({tag, ".hcount"}, hc, h);
    chk({tag, ".vcount"}, vc, v);
    chk({tag, ".active"}, act, int'(h < c.ha && v < c.va));
    chk({tag, ".hsync"}, hs, int'(m.rh[c.dly]));
    chk({tag, ".vsync"}, vs, int'(m.rv[c.dly]));
    chk({tag, ".line_end"}, le, int'(m.le));
    chk({tag, ".frame_start"}, fs, int'(m.fs));
  endtask

  // One clk: drive inputs, take the edge, advance the model, compare all three instances.
  task automatic step(bit r, bit en);
    rst = r;
    pix_en = en;
    @(posedge clk);
    #1;
    ma = mstep(ma, ca, r, en);
    mb = mstep(mb, cb, r, en);
    mc = mstep(mc, cc, r, en);
    chk_inst("a", ca, ma, a_hc, a_vc, a_act, a_hs, a_vs, a_le, a_fs);
    chk_inst("b", cb, mb, b_hc, b_vc, b_act, b_hs, b_vs, b_le, b_fs);
    chk_inst("c", cc, mc, c_hc, c_vc, c_act, c_hs, c_vs, c_le, c_fs);
  endtask

  initial begin
    vec_t vecs[8];
    int   cnt_low, cnt_le, cnt_fs, guard;
    bit   found;

    ca = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0};
    cb = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1};
    cc = '{8, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b0, 2};

    // Reset wins over pix_en; counting then starts from (0,0) and holds when pix_en is low.
    vecs[0] = '{1'b1, 1'b1, 0, 0, 1, 1, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 0, 0, 1, 1, 0, 0};
    vecs[2] = '{1'b1, 1'b1, 0, 0, 1, 1, 0, 0};
    vecs[3] = '{1'b0, 1'b1, 1, 0, 1, 1, 0, 0};
    vecs[4] = '{1'b0, 1'b0, 1, 0, 1, 1, 0, 0};
    vecs[5] = '{1'b0, 1'b1, 2, 0, 1, 1, 0, 0};
    vecs[6] = '{1'b0, 1'b1, 3, 0, 1, 1, 0, 0};
    vecs[7] = '{1'b0, 1'b0, 3, 0, 1, 1, 0, 0};
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].en);
      chk("vec.hcount", int'(b_hc), vecs[i].hc);
      chk("vec.vcount", int'(b_vc), vecs[i].vc);
      chk("vec.active", int'(b_act), vecs[i].act);
      chk("vec.hsync", int'(b_hs), vecs[i].hs);
      chk("vec.line_end", int'(b_le), vecs[i].le);
      chk("vec.frame_start", int'(b_fs), vecs[i].fs);
    end

    // One full default line at pix_en=1: hsync window, active edge, line_end and line wrap.
    step(1'b1, 1'b1);
    cnt_low = 0;
    for (int i = 1; i <= 800; i++) begin
      step(1'b0, 1'b1);
      if (a_hs == 1'b0) cnt_low++;
      if (i == 655) chk("h655.hsync0", int'(a_hs), 1);
      if (i == 656) chk("h656.hsync0", int'(a_hs), 0);
      if (i == 751) chk("h751.hsync0", int'(a_hs), 0);
      if (i == 752) chk("h752.hsync0", int'(a_hs), 1);
      if (i == 656) chk("h656.hsync1", int'(b_hs), 1);
      if (i == 657) chk("h657.hsync1", int'(b_hs), 0);
      if (i == 639) chk("h639.active", int'(b_act), 1);
      if (i == 640) chk("h640.active", int'(b_act), 0);
      if (i == 799) begin
        chk("h799.hcount", int'(a_hc), 799);
        chk("h799.line_end", int'(a_le), 1);
      end
      if (i == 800) begin
        chk("wrap.hcount", int'(a_hc), 0);
        chk("wrap.vcount", int'(a_vc), 1);
        chk("wrap.line_end", int'(a_le), 0);
      end
    end
    chk("hsync.low_ticks", cnt_low, 96);

    // pix_en at half rate: one line takes 1600 clk and line_end stays one clk wide.
    cnt_le = 0;
    for (int i = 0; i < 1600; i++) begin
      step(1'b0, i[0] == 1'b0);
      if (b_le) cnt_le++;
    end
    chk("halfrate.line_end_clks", cnt_le, 1);
    chk("halfrate.vcount", int'(b_vc), 2);

    // Tiny raster: one full frame from reset gives one frame_start and V_SYNC*H_TOTAL low clks.
    step(1'b1, 1'b0);
    cnt_low = 0;
    cnt_fs = 0;
    for (int i = 0; i < 165; i++) begin
      step(1'b0, 1'b1);
      if (c_vs == 1'b0) cnt_low++;
      if (c_fs) cnt_fs++;
    end
    chk("frame.frame_start_cnt", cnt_fs, 1);
    chk("frame.vsync_low_clks", cnt_low, 30);
    chk("frame.fs_at_origin", int'(c_fs), 1);

    // Reset in the back porch of a sync line: everything returns to idle in one clk.
    found = 1'b0;
    guard = 0;
    while (!found && guard < 400) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      found = (c_hc == 10'd13 && c_vc == 10'd8);
      guard++;
    end
    chk("midreset.reached", int'(found), 1);
    step(1'b1, 1'b1);
    chk("midreset.hcount", int'(c_hc), 0);
    chk("midreset.vcount", int'(c_vc), 0);
    chk("midreset.hsync", int'(c_hs), 0);
    chk("midreset.vsync", int'(c_vs), 1);
    chk("midreset.active", int'(c_act), 1);
    chk("midreset.strobes", int'(c_le | c_fs), 0);

    // Random pix_en with occasional reset, all instances checked against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
